// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - loadable up/down counter with terminal count, one-shot/auto-reload and done flag
module updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_val;
  logic [WIDTH-1:0] terminal;
  logic             at_terminal;

  // Terminal value follows the direction sampled on this edge
  assign terminal    = up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  assign at_terminal = (q == terminal);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q          <= '0;
      reload_val <= '0;
      state      <= IDLE;
      tc         <= 1'b0;
      done       <= 1'b0;
    end else if (load) begin
      q          <= d;
      reload_val <= d;
      state      <= COUNT;
      tc         <= 1'b0;
      done       <= 1'b0;
    end else begin
      tc <= 1'b0;
      case (state)
        COUNT: begin
          if (en) begin
            if (at_terminal) begin
              // Terminal event intercepts the wrap: reload or stop
              tc <= 1'b1;
              if (auto_reload) begin
                q <= reload_val;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else if (up) begin
              q <= q + 1'b1;
            end else begin
              q <= q - 1'b1;
            end
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// tb/tb_updown_counter.sv - directed and randomized check of updown_counter against a behavioural model
module tb_updown_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] d = '0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] q;
  logic         tc;
  logic         done;

  int compared = 0;
  int mismatched = 0;

  // Behavioural model: mode 0 idle, 1 counting, 2 finished
  int m_q, m_rv, m_mode, m_tc, m_done;

  updown_counter #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .d(d), .en(en), .up(up),
    .auto_reload(auto_reload), .q(q), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_rv = 0; m_mode = 0; m_tc = 0; m_done = 0;
  endtask

  task automatic model_edge();
    int term;
    term = up ? MOD - 1 : 0;
    if (load) begin
      m_q = int'(d); m_rv = int'(d); m_mode = 1; m_tc = 0; m_done = 0;
    end else if (m_mode == 1 && en) begin
      if (m_q == term) begin
        m_tc = 1;
        if (auto_reload) m_q = m_rv;
        else begin
          m_mode = 2; m_done = 1;
        end
      end else begin
        m_q = (m_q + (up ? 1 : MOD - 1)) % MOD;
        m_tc = 0;
      end
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".q"}, 32'(q), 32'(m_q));
    check({tag, ".tc"}, 32'(tc), 32'(m_tc));
    check({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic l, input logic [W-1:0] dv, input logic e, input logic u, input logic ar);
    load = l; d = dv; en = e; up = u; auto_reload = ar;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    reset_n = 1'b1;
    drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    repeat (5) tick("idle");

    // One-shot down from 3
    drive(1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    tick("os_load");
    load = 1'b0;
    repeat (4) tick("os_cnt");
    check("os_tc_lit", 32'(tc), 32'd1);
    check("os_done_lit", 32'(done), 32'd1);
    repeat (5) tick("os_hold");
    check("os_q_lit", 32'(q), 32'd0);

    // Auto-reload up from 13
    drive(1'b1, 4'd13, 1'b1, 1'b1, 1'b1);
    tick("ar_load");
    load = 1'b0;
    repeat (9) tick("ar_cnt");

    // Reload value equal to terminal keeps tc high
    drive(1'b1, 4'd15, 1'b1, 1'b1, 1'b1);
    tick("artc_load");
    load = 1'b0;
    repeat (4) tick("artc_cnt");
    check("artc_tc_lit", 32'(tc), 32'd1);

    // Enable gating and direction change
    drive(1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
    tick("gate_load");
    load = 1'b0;
    en = 1'b1; tick("gate_e1");
    en = 1'b0; tick("gate_e0a");
    tick("gate_e0b");
    en = 1'b1; tick("gate_e1b");
    check("gate_q_lit", 32'(q), 32'd7);
    up = 1'b0;
    repeat (2) tick("gate_dn");
    check("gate_dn_lit", 32'(q), 32'd5);

    // Load colliding with a terminal event
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    tick("col_pre");
    drive(1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    tick("col_load");
    check("col_q_lit", 32'(q), 32'd9);
    load = 1'b0;
    tick("col_after");

    // Asynchronous reset mid-count
    drive(1'b1, 4'd5, 1'b1, 1'b1, 1'b0);
    tick("rst_load");
    load = 1'b0;
    repeat (2) tick("rst_cnt");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    reset_n = 1'b1;
    repeat (3) tick("rst_release");

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 9) == 0);
      d = W'($urandom_range(0, MOD - 1));
      if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 1) ? '1 : '0;
      en = ($urandom_range(0, 3) != 0);
      up = 1'($urandom_range(0, 1));
      auto_reload = 1'($urandom_range(0, 1));
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
